// File: rtl/game_state_controller.sv
// Round-level game state for the frog game: lives, level, death hold, respawn and game over.
// Optional post-respawn collision immunity is enabled by defining GAME_GRACE_PERIOD_EN.
module game_state_controller #(
  parameter int unsigned START_LIVES  = 3,
  parameter int unsigned DEATH_FRAMES = 60,
  parameter int unsigned GRACE_FRAMES = 30,
  parameter int unsigned MAX_LEVEL    = 15
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Frame_Tick,
  input  logic       i_Has_Collided,
  input  logic       i_Reached_Goal,
  input  logic       i_Start,
  output logic [1:0] o_State,
  output logic [1:0] o_Lives,
  output logic [3:0] o_Level,
  output logic       o_Frog_Respawn,
  output logic       o_Freeze,
  output logic       o_Game_Over
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_DYING = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  // Death and grace counters share one width wide enough for either frame count.
  localparam int unsigned CNT_MAX = (DEATH_FRAMES > GRACE_FRAMES) ? DEATH_FRAMES : GRACE_FRAMES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEATH_LAST = CNT_W'(DEATH_FRAMES - 1);
  localparam logic [1:0]       LIVES_INIT = 2'(START_LIVES);
  localparam logic [3:0]       LEVEL_MAX  = 4'(MAX_LEVEL);

  state_t           state_q,     state_d;
  logic [1:0]       lives_q,     lives_d;
  logic [3:0]       level_q,     level_d;
  logic             respawn_q,   respawn_d;
  logic             freeze_q,    freeze_d;
  logic             game_over_q, game_over_d;
  logic [CNT_W-1:0] death_cnt_q, death_cnt_d;
  logic             start_prev_q, start_prev_d;
  logic             start_evt_s;
  logic             immune_s;

`ifdef GAME_GRACE_PERIOD_EN
  localparam logic [CNT_W-1:0] GRACE_INIT = CNT_W'(GRACE_FRAMES);
  logic [CNT_W-1:0] grace_cnt_q, grace_cnt_d;
  assign immune_s = (grace_cnt_q != CNT_ZERO);
`else
  assign immune_s = 1'b0;
`endif

  assign start_evt_s = i_Start & ~start_prev_q;

  // Next-state, counter and output decode
  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    level_d      = level_q;
    respawn_d    = 1'b0;
    death_cnt_d  = death_cnt_q;
    start_prev_d = i_Start;
`ifdef GAME_GRACE_PERIOD_EN
    grace_cnt_d  = grace_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_evt_s) begin
          state_d   = ST_PLAY;
          lives_d   = LIVES_INIT;
          level_d   = 4'd0;
          respawn_d = 1'b1;
`ifdef GAME_GRACE_PERIOD_EN
          grace_cnt_d = CNT_ZERO;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PLAY: begin
`ifdef GAME_GRACE_PERIOD_EN
        if (i_Frame_Tick && immune_s) begin
          grace_cnt_d = grace_cnt_q - CNT_ONE;
        end else begin
          grace_cnt_d = grace_cnt_q;
        end
`endif
        // Collision outranks a same-cycle goal
        if (i_Has_Collided && !immune_s) begin
          state_d     = ST_DYING;
          lives_d     = (lives_q != 2'd0) ? (lives_q - 2'd1) : 2'd0;
          death_cnt_d = CNT_ZERO;
        end else if (i_Reached_Goal) begin
          level_d   = (level_q != LEVEL_MAX) ? (level_q + 4'd1) : LEVEL_MAX;
          respawn_d = 1'b1;
        end else begin
          state_d = ST_PLAY;
        end
      end

      ST_DYING: begin
        if (i_Frame_Tick) begin
          if (death_cnt_q == DEATH_LAST) begin
            death_cnt_d = CNT_ZERO;
            if (lives_q == 2'd0) begin
              state_d = ST_OVER;
            end else begin
              state_d   = ST_PLAY;
              respawn_d = 1'b1;
`ifdef GAME_GRACE_PERIOD_EN
              grace_cnt_d = GRACE_INIT;
`endif
            end
          end else begin
            death_cnt_d = death_cnt_q + CNT_ONE;
          end
        end else begin
          death_cnt_d = death_cnt_q;
        end
      end

      ST_OVER: begin
        if (start_evt_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OVER;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    freeze_d    = (state_d != ST_PLAY);
    game_over_d = (state_d == ST_OVER);
  end

  // State and output registers
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q      <= ST_IDLE;
      lives_q      <= LIVES_INIT;
      level_q      <= 4'd0;
      respawn_q    <= 1'b0;
      freeze_q     <= 1'b1;
      game_over_q  <= 1'b0;
      death_cnt_q  <= CNT_ZERO;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      respawn_q    <= respawn_d;
      freeze_q     <= freeze_d;
      game_over_q  <= game_over_d;
      death_cnt_q  <= death_cnt_d;
      start_prev_q <= start_prev_d;
    end
  end

`ifdef GAME_GRACE_PERIOD_EN
  // Grace counter register
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      grace_cnt_q <= CNT_ZERO;
    end else begin
      grace_cnt_q <= grace_cnt_d;
    end
  end
`endif

  assign o_State        = state_q;
  assign o_Lives        = lives_q;
  assign o_Level        = level_q;
  assign o_Frog_Respawn = respawn_q;
  assign o_Freeze       = freeze_q;
  assign o_Game_Over    = game_over_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Directed scoreboard bench for game_state_controller; expectations are queued as
// stimulus is driven and popped against the registered outputs one cycle later.
module tb_game_state_controller;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_PLAY  = 2'b01;
  localparam logic [1:0] S_DYING = 2'b10;
  localparam logic [1:0] S_OVER  = 2'b11;

  logic       i_Clk;
  logic       i_Rst_L;
  logic       i_Frame_Tick;
  logic       i_Has_Collided;
  logic       i_Reached_Goal;
  logic       i_Start;
  logic [1:0] o_State;
  logic [1:0] o_Lives;
  logic [3:0] o_Level;
  logic       o_Frog_Respawn;
  logic       o_Freeze;
  logic       o_Game_Over;

  typedef struct {
    string       tag;
    logic [10:0] v;
  } exp_t;

  exp_t sb_q[$];
  int   total;
  int   bad;

  game_state_controller dut (
    .i_Clk          (i_Clk),
    .i_Rst_L        (i_Rst_L),
    .i_Frame_Tick   (i_Frame_Tick),
    .i_Has_Collided (i_Has_Collided),
    .i_Reached_Goal (i_Reached_Goal),
    .i_Start        (i_Start),
    .o_State        (o_State),
    .o_Lives        (o_Lives),
    .o_Level        (o_Level),
    .o_Frog_Respawn (o_Frog_Respawn),
    .o_Freeze       (o_Freeze),
    .o_Game_Over    (o_Game_Over)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [1:0] st, input logic [1:0] lv,
                      input logic [3:0] lev, input logic rs, input logic fz, input logic go);
    exp_t e;
    e.tag = tag;
    e.v   = {st, lv, lev, rs, fz, go};
    sb_q.push_back(e);
  endtask

  task automatic chk();
    exp_t        e;
    logic [10:0] obs;
    obs = {o_State, o_Lives, o_Level, o_Frog_Respawn, o_Freeze, o_Game_Over};
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty: got %h expected a queued entry", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.v) else begin
        bad++;
        $error("FAIL %s: got st/lv/lev/rs/fz/go=%b expected %b", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      i_Frame_Tick = 1'b1;
      cyc();
      i_Frame_Tick = 1'b0;
      cyc();
    end
  endtask

  task automatic wait_rehit();
`ifdef GAME_GRACE_PERIOD_EN
    ticks(30);
`else
    cyc();
`endif
  endtask

  initial begin
    logic [3:0] lev;
    total = 0;
    bad   = 0;
    i_Rst_L        = 1'b0;
    i_Frame_Tick   = 1'b0;
    i_Has_Collided = 1'b0;
    i_Reached_Goal = 1'b0;
    i_Start        = 1'b0;
    repeat (3) cyc();
    push("reset", S_IDLE, 2'd3, 4'd0, 1'b0, 1'b1, 1'b0);
    chk();

    i_Rst_L = 1'b1;
    push("idle", S_IDLE, 2'd3, 4'd0, 1'b0, 1'b1, 1'b0);
    cyc(); chk();

    i_Start = 1'b1;
    push("start", S_PLAY, 2'd3, 4'd0, 1'b1, 1'b0, 1'b0);
    cyc(); chk();
    push("start_held", S_PLAY, 2'd3, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(); chk();
    i_Start = 1'b0;

    i_Has_Collided = 1'b1;
    push("hit1", S_DYING, 2'd2, 4'd0, 1'b0, 1'b1, 1'b0);
    cyc(); chk();
    ticks(59);
    push("dying59", S_DYING, 2'd2, 4'd0, 1'b0, 1'b1, 1'b0);
    chk();
    i_Frame_Tick = 1'b1;
    push("respawn1", S_PLAY, 2'd2, 4'd0, 1'b1, 1'b0, 1'b0);
    cyc(); chk();
    i_Frame_Tick = 1'b0;

`ifdef GAME_GRACE_PERIOD_EN
    ticks(29);
    push("grace_immune", S_PLAY, 2'd2, 4'd0, 1'b0, 1'b0, 1'b0);
    chk();
    ticks(1);
`else
    cyc();
`endif
    push("hit2", S_DYING, 2'd1, 4'd0, 1'b0, 1'b1, 1'b0);
    chk();

    ticks(59);
    i_Frame_Tick = 1'b1;
    push("respawn2", S_PLAY, 2'd1, 4'd0, 1'b1, 1'b0, 1'b0);
    cyc(); chk();
    i_Frame_Tick = 1'b0;
    wait_rehit();
    push("hit3", S_DYING, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    chk();

    ticks(59);
    i_Frame_Tick = 1'b1;
    push("over", S_OVER, 2'd0, 4'd0, 1'b0, 1'b1, 1'b1);
    cyc(); chk();
    i_Frame_Tick   = 1'b0;
    i_Has_Collided = 1'b0;
    push("over_hold", S_OVER, 2'd0, 4'd0, 1'b0, 1'b1, 1'b1);
    cyc(); chk();

    i_Start = 1'b1;
    push("to_idle", S_IDLE, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    cyc(); chk();
    i_Start = 1'b0;
    cyc();
    i_Start = 1'b1;
    push("restart", S_PLAY, 2'd3, 4'd0, 1'b1, 1'b0, 1'b0);
    cyc(); chk();
    i_Start = 1'b0;

    for (int i = 1; i <= 17; i++) begin
      lev = (i > 15) ? 4'd15 : 4'(i);
      i_Reached_Goal = 1'b1;
      push("goal", S_PLAY, 2'd3, lev, 1'b1, 1'b0, 1'b0);
      cyc(); chk();
      i_Reached_Goal = 1'b0;
      cyc();
    end

    i_Has_Collided = 1'b1;
    i_Reached_Goal = 1'b1;
    push("hit_and_goal", S_DYING, 2'd2, 4'd15, 1'b0, 1'b1, 1'b0);
    cyc(); chk();
    i_Has_Collided = 1'b0;
    i_Reached_Goal = 1'b0;

    ticks(30);
    push("mid_dying", S_DYING, 2'd2, 4'd15, 1'b0, 1'b1, 1'b0);
    chk();
    i_Rst_L = 1'b0;
    #1;
    push("async_reset", S_IDLE, 2'd3, 4'd0, 1'b0, 1'b1, 1'b0);
    chk();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
